// File: rtl/gba_bus_pkg.sv
// Shared widths, FSM state encoding and address helper for the GBA ROM bridge.
package gba_bus_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_WRITE,
    ST_DRAIN
  } state_t;

  // Halfword address increment: the low 16 bits wrap, the high byte is kept.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:16], a[15:0] + 16'd1};
  endfunction

endpackage

// File: rtl/gba_rom_bus_if.sv
// Backing-memory request/ack channel between the ROM bridge and its store.
interface gba_rom_bus_if;
  import gba_bus_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/gba_sync.sv
// Multi-flop synchroniser for one asynchronous GBA strobe, with edge pulses.
// STAGES must be at least 2; edges compare the two oldest flops.
module gba_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;

  // Shift the pad value through the chain; sr[0] is the metastable stage.
  always_ff @(posedge clk) begin
    // NOTE: the chain resets to 1 (strobe deasserted) so leaving reset with an
    // idle bus shows no edge; sequential state is always assigned with <=.
    if (!rst) sr <= '1;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign level = sr[STAGES-1];
  assign rise  =  sr[STAGES-2] & ~sr[STAGES-1];
  assign fall  = ~sr[STAGES-2] &  sr[STAGES-1];

endmodule

// File: rtl/gba_rom_bus.sv
// GBA cartridge ROM bus bridge: turns synchronised GBA strobes into
// single-outstanding requests on the backing-memory channel, with prefetch.
module gba_rom_bus
  import gba_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gba_ncs,
  input  logic              gba_nrd,
  input  logic              gba_nwr,
  input  logic [DATA_W-1:0] gba_ad_in,
  input  logic [7:0]        gba_a_in,
  output logic [DATA_W-1:0] gba_ad_out,
  output logic              gba_ad_oe,
  gba_rom_bus_if.master     mem,
  output logic              late_err,
  output logic              busy
);

  state_t            state;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] pend_data;
  logic              wr_pend;

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic nrd_lvl, nrd_rise, nrd_fall;
  logic nwr_lvl, nwr_rise, nwr_fall_unused;
  logic req_done;

  gba_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(gba_ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  gba_sync #(.STAGES(SYNC_STAGES)) u_sync_nrd (
    .clk(clk), .rst(rst), .d(gba_nrd),
    .level(nrd_lvl), .rise(nrd_rise), .fall(nrd_fall)
  );

  gba_sync #(.STAGES(SYNC_STAGES)) u_sync_nwr (
    .clk(clk), .rst(rst), .d(gba_nwr),
    .level(nwr_lvl), .rise(nwr_rise), .fall(nwr_fall_unused)
  );

  // An ack only counts while a request is actually open.
  assign req_done   = mem.mem_req & mem.mem_ack;

  assign gba_ad_out = rd_buf;
  assign gba_ad_oe  = ~ncs_lvl & ~nrd_lvl & nwr_lvl;
  assign busy       = (state != ST_IDLE);

  // Transaction FSM: owns the request channel, read buffer and pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rd_buf        <= '0;
      pend_data     <= '0;
      wr_pend       <= 1'b0;
      late_err      <= 1'b0;
    end else begin
      // NOTE: late_err is defaulted low every cycle, so any set below is a
      // one-cycle pulse without extra clearing logic.
      late_err <= 1'b0;

      if (ncs_rise && state != ST_IDLE && state != ST_DRAIN) begin
        // Chip select released: abandon the burst, but let an open request finish.
        wr_pend <= 1'b0;
        if (mem.mem_req && !mem.mem_ack) begin
          state <= ST_DRAIN;
        end else begin
          mem.mem_req <= 1'b0;
          mem.mem_we  <= 1'b0;
          state       <= ST_IDLE;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (ncs_fall) begin
              mem.mem_addr <= {gba_a_in, gba_ad_in};
              mem.mem_we   <= 1'b0;
              mem.mem_req  <= 1'b1;
              state        <= ST_FETCH;
            end
          end

          ST_FETCH: begin
            // After a write the request drops for a cycle; raise the prefetch here.
            if (!mem.mem_req) begin
              mem.mem_req <= 1'b1;
            end else if (mem.mem_ack) begin
              rd_buf      <= mem.mem_rdata;
              mem.mem_req <= 1'b0;
              state       <= ST_HOLD;
            end
            if (nrd_fall) late_err <= 1'b1;
            if (nwr_rise) begin
              if (wr_pend) begin
                late_err <= 1'b1;
              end else begin
                wr_pend   <= 1'b1;
                pend_data <= gba_ad_in;
              end
            end
          end

          ST_HOLD: begin
            if (wr_pend) begin
              mem.mem_wdata <= pend_data;
              mem.mem_we    <= 1'b1;
              mem.mem_req   <= 1'b1;
              wr_pend       <= 1'b0;
              state         <= ST_WRITE;
            end else if (nrd_rise) begin
              mem.mem_addr <= next_addr(mem.mem_addr);
              mem.mem_we   <= 1'b0;
              mem.mem_req  <= 1'b1;
              state        <= ST_FETCH;
            end else if (nwr_rise) begin
              mem.mem_wdata <= gba_ad_in;
              mem.mem_we    <= 1'b1;
              mem.mem_req   <= 1'b1;
              state         <= ST_WRITE;
            end
          end

          ST_WRITE: begin
            if (req_done) begin
              mem.mem_req  <= 1'b0;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= next_addr(mem.mem_addr);
              state        <= ST_FETCH;
            end
          end

          ST_DRAIN: begin
            // Read data returned here is discarded; rd_buf keeps its value.
            if (req_done) begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              wr_pend     <= 1'b0;
              state       <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gba_rom_bus.sv
// Self-checking bench for gba_rom_bus: directed corner cases plus randomized
// bursts, compared against a transaction-level model of the ROM bridge.
module tb_gba_rom_bus;
  import gba_bus_pkg::*;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic        clk;
  logic        rst;
  logic        gba_ncs, gba_nrd, gba_nwr;
  logic [15:0] gba_ad_in;
  logic [7:0]  gba_a_in;
  logic [15:0] gba_ad_out;
  logic        gba_ad_oe;
  logic        late_err;
  logic        busy;

  gba_rom_bus_if bus ();

  gba_rom_bus #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .gba_ncs    (gba_ncs),
    .gba_nrd    (gba_nrd),
    .gba_nwr    (gba_nwr),
    .gba_ad_in  (gba_ad_in),
    .gba_a_in   (gba_a_in),
    .gba_ad_out (gba_ad_out),
    .gba_ad_oe  (gba_ad_oe),
    .mem        (bus),
    .late_err   (late_err),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  int   ack_lat = 3;
  req_t log_q[$];
  req_t exp_q[$];
  logic [15:0] ref_mem  [logic [23:0]];
  logic [15:0] resp_mem [logic [23:0]];

  logic [23:0] cur;
  logic [15:0] exp_rdbuf;
  int          exp_late = 0;
  int          late_hi = 0;
  int          late_pulses = 0;
  logic        late_prev = 1'b0;

  logic [23:0] base;
  int          nops;
  int          spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Unwritten memory contents follow a fixed address-derived pattern.
  function automatic logic [15:0] dflt(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h3C};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] resp_rd(input logic [23:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [23:0] inc16(input logic [23:0] a);
    logic [15:0] lo;
    lo = a[15:0] + 16'd1;
    return {a[23:16], lo};
  endfunction

  function automatic logic [40:0] pack(input req_t r);
    return {r.we, r.addr, (r.we ? r.wdata : 16'h0000)};
  endfunction

  // Memory responder: acks each request after ack_lat cycles, logs completed
  // requests and tolerates requests dropped before their ack.
  initial begin
    req_t cap;
    int   cnt;
    bit   active;
    active = 1'b0;
    cnt = 0;
    cap = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        active = 1'b0;
      end else if (!bus.mem_req) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          cap = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
        end
        cnt++;
        if (cnt >= ack_lat) begin
          check("req_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, cap);
          if (cap.we) resp_mem[cap.addr] = cap.wdata;
          else        bus.mem_rdata = resp_rd(cap.addr);
          log_q.push_back(cap);
          bus.mem_ack = 1'b1;
          active = 1'b0;
        end
      end
    end
  end

  // late_err monitor: counts high cycles and distinct pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (late_err) late_hi++;
      if (late_err && !late_prev) late_pulses++;
      late_prev = late_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_log(input string tag, input int budget);
    int n;
    n = 0;
    while (log_q.size() < exp_q.size() && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, log_q.size(), exp_q.size());
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.mem_req && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, bus.mem_req, 1);
  endtask

  task automatic start_txn(input logic [23:0] b);
    gba_a_in  = b[23:16];
    gba_ad_in = b[15:0];
    gba_ncs   = 1'b0;
    cur = b;
    exp_q.push_back('{we: 1'b0, addr: b, wdata: 16'h0000});
  endtask

  task automatic first_fetch(input string tag);
    wait_log(tag, 80);
    tick(2);
    exp_rdbuf = ref_rd(cur);
  endtask

  task automatic do_read();
    gba_nrd = 1'b0;
    tick(4);
    check($sformatf("rd_oe@%06h", cur), gba_ad_oe, 1);
    check($sformatf("rd_data@%06h", cur), gba_ad_out, ref_rd(cur));
    gba_nrd = 1'b1;
    cur = inc16(cur);
    exp_q.push_back('{we: 1'b0, addr: cur, wdata: 16'h0000});
    exp_rdbuf = ref_rd(cur);
    wait_log("rd_prefetch", 80);
    tick(2);
  endtask

  task automatic nwr_pulse(input logic [15:0] d);
    gba_ad_in = d;
    tick(1);
    gba_nwr = 1'b0;
    tick(3);
    check("wr_oe", gba_ad_oe, 0);
    gba_nwr = 1'b1;
    tick(3);
  endtask

  task automatic model_write(input logic [15:0] d);
    exp_q.push_back('{we: 1'b1, addr: cur, wdata: d});
    ref_mem[cur] = d;
    cur = inc16(cur);
    exp_q.push_back('{we: 1'b0, addr: cur, wdata: 16'h0000});
    exp_rdbuf = ref_rd(cur);
  endtask

  task automatic do_write(input logic [15:0] d);
    nwr_pulse(d);
    model_write(d);
    wait_log("wr_done", 80);
    tick(2);
  endtask

  task automatic end_txn();
    gba_ncs = 1'b1;
    tick(4);
    check("end_busy", busy, 0);
    check("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("req%0d", i), pack(log_q[i]), pack(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   bus.mem_req, 0);
    check({tag, "_we"},    bus.mem_we, 0);
    check({tag, "_addr"},  bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_adout"}, gba_ad_out, 0);
    check({tag, "_oe"},    gba_ad_oe, 0);
    check({tag, "_late"},  late_err, 0);
    check({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    gba_ncs = 1'b1;
    gba_nrd = 1'b1;
    gba_nwr = 1'b1;
    gba_ad_in = 16'h0000;
    gba_a_in = 8'h00;
    exp_rdbuf = 16'h0000;
    cur = '0;
    tick(3);
    check_zero_outputs("reset");
    rst = 1'b1;
    tick(3);

    // Basic fetch and read-out of a known word.
    ref_mem[24'h123456]  = 16'hBEEF;
    resp_mem[24'h123456] = 16'hBEEF;
    ack_lat = 3;
    start_txn(24'h123456);
    first_fetch("basic_fetch");
    check("basic_addr", log_q[0].addr, 24'h123456);
    check("basic_we", log_q[0].we, 0);
    do_read();
    end_txn();

    // Burst across the low-half wrap.
    start_txn(24'h00FFFE);
    first_fetch("wrap_fetch");
    do_read();
    do_read();
    do_read();
    end_txn();

    // Read strobe arrives while the fetch is still outstanding.
    ack_lat = 20;
    start_txn(24'h345670);
    wait_req("late_req");
    gba_nrd = 1'b0;
    tick(4);
    check("late_stale", gba_ad_out, exp_rdbuf);
    wait_log("late_fetch", 80);
    tick(2);
    check("late_fresh", gba_ad_out, ref_rd(cur));
    exp_late++;
    gba_nrd = 1'b1;
    cur = inc16(cur);
    exp_q.push_back('{we: 1'b0, addr: cur, wdata: 16'h0000});
    exp_rdbuf = ref_rd(cur);
    wait_log("late_prefetch", 80);
    tick(2);
    end_txn();

    // Write strobe during a pending fetch executes after the read ack.
    ack_lat = 12;
    start_txn(24'h2200F0);
    wait_req("pend_req");
    nwr_pulse(16'hA5A5);
    model_write(16'hA5A5);
    wait_log("pend_done", 120);
    tick(2);
    ack_lat = 2;
    do_read();
    end_txn();

    // Second write strobe while one is already pending is dropped.
    ack_lat = 25;
    start_txn(24'h550010);
    wait_req("dbl_req");
    nwr_pulse(16'h1111);
    nwr_pulse(16'h2222);
    exp_late++;
    model_write(16'h1111);
    wait_log("dbl_done", 150);
    tick(2);
    end_txn();

    // Chip select released with a prefetch outstanding; ncs fall during the
    // drain must not start a new transaction.
    ack_lat = 3;
    start_txn(24'h771234);
    first_fetch("drain_fetch");
    ack_lat = 15;
    gba_nrd = 1'b0;
    tick(4);
    check("drain_rd", gba_ad_out, ref_rd(cur));
    gba_nrd = 1'b1;
    cur = inc16(cur);
    exp_q.push_back('{we: 1'b0, addr: cur, wdata: 16'h0000});
    wait_req("drain_req");
    gba_ncs = 1'b1;
    tick(4);
    check("drain_busy", busy, 1);
    gba_a_in = 8'h99;
    gba_ad_in = 16'h8888;
    gba_ncs = 1'b0;
    wait_log("drain_ack", 80);
    tick(3);
    check("drain_idle", busy, 0);
    check("drain_rdbuf", gba_ad_out, exp_rdbuf);
    tick(10);
    check("drain_no_new", log_q.size(), exp_q.size());
    check("drain_no_req", bus.mem_req, 0);
    end_txn();

    // Reset pulse in the middle of a fetch.
    ack_lat = 30;
    start_txn(24'h0ABCDE);
    wait_req("rst_req");
    tick(2);
    rst = 1'b0;
    gba_ncs = 1'b1;
    tick(1);
    check_zero_outputs("midrst");
    rst = 1'b1;
    exp_rdbuf = 16'h0000;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.mem_req || busy || late_err) spur++;
    end
    check("no_spurious", spur, 0);
    check("rst_log_empty", log_q.size(), 0);
    log_q.delete();
    exp_q.delete();

    // Randomized bursts of reads and writes.
    for (int t = 0; t < 16; t++) begin
      base = {8'($urandom), 16'($urandom)};
      if ($urandom_range(0, 2) == 0) base[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
      ack_lat = $urandom_range(1, 6);
      start_txn(base);
      first_fetch("rnd_fetch");
      nops = $urandom_range(1, 4);
      for (int k = 0; k < nops; k++) begin
        if ($urandom_range(0, 2) == 0) do_write(16'($urandom));
        else                            do_read();
      end
      end_txn();
    end

    check("late_cycles", late_hi, exp_late);
    check("late_pulses", late_pulses, exp_late);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
